apb_regfile_slave: RTL and testbench

//  APB4 completer register bank. Sits directly downstream of the APB clock-domain bridge's b-side master port.

---
 rtl/apb_pkg.sv | 14 +
 rtl/apb_regfile_slave_if.sv | 30 +++
 rtl/apb_wait_gen.sv | 37 +++
 rtl/apb_regfile_slave.sv | 196 +++++++++++++++++++
 tb/tb_apb_regfile_slave.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB completer types and constants
package apb_pkg;

    localparam int APB_AW     = 32;
    localparam int APB_DW     = 32;
    localparam int APB_BOFF_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_regfile_slave_if.sv
// rtl/apb_regfile_slave_if.sv - APB4 bus bundle with requester/completer modports
interface apb_regfile_slave_if
    import apb_pkg::*;
#(
    parameter int AW     = APB_AW,
    parameter int DW     = APB_DW,
    parameter int PROT_W = 3
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [PROT_W-1:0] pprot;
    logic [AW-1:0]     paddr;
    logic [DW-1:0]     pwdata;
    logic [DW/8-1:0]   pstrb;
    logic              pready;
    logic              pslverr;
    logic [DW-1:0]     prdata;

    modport master (
        output psel, penable, pwrite, pprot, paddr, pwdata, pstrb,
        input  pready, pslverr, prdata
    );

    modport slave (
        input  psel, penable, pwrite, pprot, paddr, pwdata, pstrb,
        output pready, pslverr, prdata
    );

endinterface

// File: rtl/apb_wait_gen.sv
// rtl/apb_wait_gen.sv - loadable down-counter producing the pready-set strobe
module apb_wait_gen #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    input  logic          en_i,
    output logic          fire_o
);
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires in the last wait cycle so pready rises on the following edge.
    assign fire_o = en_i && (cnt_q == CW'(1));

endmodule

// File: rtl/apb_regfile_slave.sv
// rtl/apb_regfile_slave.sv - APB4 register bank with wait states and PSLVERR; optional APB_REGFILE_PROT_EN
module apb_regfile_slave
    import apb_pkg::*;
#(
    parameter int          AW        = APB_AW,
    parameter int          DW        = APB_DW,
    parameter int          PROT_W    = 3,
    parameter int          NREG      = 8,
    parameter int          WAIT_CYC  = 0,
    parameter logic [31:0] ID_VALUE  = 32'hA5B0_0001,
    parameter logic [31:0] RST_VAL   = 32'h0,
    parameter int          PRIV_BASE = 4
) (
    input  logic                 pclk,
    input  logic                 preset_n,
    apb_regfile_slave_if.slave   apb,
    output logic [NREG*DW-1:0]   reg_q,
    output logic [NREG-1:0]      wr_pulse
);
    localparam int IW = $clog2(NREG);
    localparam int XW = AW - APB_BOFF_W;
    localparam int SW = DW / 8;

    apb_state_e      state_q, state_d;
    logic            pready_q, pready_d;
    logic            pslverr_q, pslverr_d;
    logic [DW-1:0]   prdata_q, prdata_d;
    logic [NREG-1:0] wr_pulse_q, wr_pulse_d;

    logic [IW-1:0]   idx_q;
    logic            err_q, wr_q;
    logic [DW-1:0]   wdata_q;
    logic [SW-1:0]   strb_q;
    logic [DW-1:0]   regs_q [1:NREG-1];

    logic            latch, load, cnt_en, cnt_clr, fire, commit;

    logic [XW-1:0]   xidx_c;
    logic [IW-1:0]   idx_c;
    logic            err_c, priv_hit_c;
    logic            unused_prot;

    assign xidx_c     = apb.paddr[AW-1:APB_BOFF_W];
    assign idx_c      = apb.paddr[APB_BOFF_W +: IW];
    assign priv_hit_c = ~apb.pprot[0] && (xidx_c >= XW'(PRIV_BASE));
    assign unused_prot = ^{apb.pprot, priv_hit_c};

    always_comb begin
        err_c = (apb.paddr[APB_BOFF_W-1:0] != '0)
             || (xidx_c >= XW'(NREG))
             || (apb.pwrite && xidx_c == '0);
`ifdef APB_REGFILE_PROT_EN
        err_c = err_c || priv_hit_c;
`endif
    end

    function automatic logic [DW-1:0] resp_data(input logic          err,
                                                 input logic          wr,
                                                 input logic [IW-1:0] idx,
                                                 input logic [NREG*DW-1:0] flat);
        logic [DW-1:0] r;
        r = '0;
        if (!err && !wr) begin
            for (int i = 0; i < NREG; i++) begin
                if (idx == IW'(i)) r = flat[i*DW +: DW];
            end
        end
        return r;
    endfunction

    apb_wait_gen #(.CW(4)) u_wait_gen (
        .clk        (pclk),
        .rst_n      (preset_n),
        .clr_i      (cnt_clr),
        .load_i     (load),
        .load_val_i (4'(WAIT_CYC)),
        .en_i       (cnt_en),
        .fire_o     (fire)
    );

    always_comb begin
        state_d    = state_q;
        pready_d   = pready_q;
        pslverr_d  = pslverr_q;
        prdata_d   = prdata_q;
        wr_pulse_d = '0;
        latch      = 1'b0;
        load       = 1'b0;
        cnt_en     = 1'b0;
        cnt_clr    = 1'b0;
        commit     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (apb.psel && !apb.penable) begin
                    latch = 1'b1;
                    load  = 1'b1;
                    if (WAIT_CYC == 0) begin
                        // No wait states: respond from the live setup-phase decode.
                        pready_d  = 1'b1;
                        pslverr_d = err_c;
                        prdata_d  = resp_data(err_c, apb.pwrite, idx_c, reg_q);
                        state_d   = ST_DONE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_en = 1'b1;
                if (!apb.psel) begin
                    cnt_clr  = 1'b1;
                    pready_d = 1'b0;
                    state_d  = ST_IDLE;
                end else if (fire) begin
                    pready_d  = 1'b1;
                    pslverr_d = err_q;
                    prdata_d  = resp_data(err_q, wr_q, idx_q, reg_q);
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
                prdata_d  = '0;
                state_d   = ST_IDLE;
                if (apb.psel && apb.penable && wr_q && !err_q) begin
                    commit             = 1'b1;
                    wr_pulse_d[idx_q]  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q    <= ST_IDLE;
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
            prdata_q   <= '0;
            wr_pulse_q <= '0;
        end else begin
            state_q    <= state_d;
            pready_q   <= pready_d;
            pslverr_q  <= pslverr_d;
            prdata_q   <= prdata_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            idx_q   <= '0;
            err_q   <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
        end else if (latch) begin
            idx_q   <= idx_c;
            err_q   <= err_c;
            wr_q    <= apb.pwrite;
            wdata_q <= apb.pwdata;
            strb_q  <= apb.pstrb;
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            for (int i = 1; i < NREG; i++) regs_q[i] <= RST_VAL;
        end else if (commit) begin
            for (int i = 1; i < NREG; i++) begin
                if (idx_q == IW'(i)) begin
                    for (int b = 0; b < SW; b++) begin
                        if (strb_q[b]) regs_q[i][b*8 +: 8] <= wdata_q[b*8 +: 8];
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NREG; g++) begin : g_flat
        if (g == 0) begin : g_id
            assign reg_q[DW-1:0] = ID_VALUE;
        end else begin : g_rw
            assign reg_q[g*DW +: DW] = regs_q[g];
        end
    end

    assign apb.pready  = pready_q;
    assign apb.pslverr = pslverr_q;
    assign apb.prdata  = prdata_q;
    assign wr_pulse    = wr_pulse_q;

endmodule

// File: tb/tb_apb_regfile_slave.sv
// tb/tb_apb_regfile_slave.sv - scoreboard bench for apb_regfile_slave (zero-wait and 3-wait instances)
module tb_apb_regfile_slave;

    localparam logic [31:0] ID = 32'hA5B0_0001;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    logic        pclk = 1'b0;
    logic        preset_n = 1'b0;
    logic        dsel, psel, penable, pwrite;
    logic [2:0]  pprot;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pstrb;
    logic [255:0] regq0, regq1;
    logic [7:0]  wp0, wp1;

    logic [31:0] m0 [8];
    logic [31:0] m1 [8];
    exp_t q0[$];
    exp_t q1[$];
    int checks = 0;
    int errors = 0;
    int acc0 = 0;
    int acc1 = 0;

    always #5 pclk = ~pclk;

    apb_regfile_slave_if #(.AW(32), .DW(32), .PROT_W(3)) bus0 ();
    apb_regfile_slave_if #(.AW(32), .DW(32), .PROT_W(3)) bus1 ();

    assign bus0.psel    = psel & ~dsel;
    assign bus1.psel    = psel & dsel;
    assign bus0.penable = penable;
    assign bus1.penable = penable;
    assign bus0.pwrite  = pwrite;
    assign bus1.pwrite  = pwrite;
    assign bus0.pprot   = pprot;
    assign bus1.pprot   = pprot;
    assign bus0.paddr   = paddr;
    assign bus1.paddr   = paddr;
    assign bus0.pwdata  = pwdata;
    assign bus1.pwdata  = pwdata;
    assign bus0.pstrb   = pstrb;
    assign bus1.pstrb   = pstrb;

    apb_regfile_slave #(.WAIT_CYC(0)) u0 (
        .pclk(pclk), .preset_n(preset_n), .apb(bus0), .reg_q(regq0), .wr_pulse(wp0)
    );

    apb_regfile_slave #(.WAIT_CYC(3)) u1 (
        .pclk(pclk), .preset_n(preset_n), .apb(bus1), .reg_q(regq1), .wr_pulse(wp1)
    );

    function automatic logic [255:0] pack(input logic [31:0] m [8]);
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = m[i];
        return v;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_regs(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic mon_cmp(input bit d, input logic err, input logic [31:0] rd, input int lat);
        exp_t e;
        if (d ? (q1.size() == 0) : (q0.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp dut%0d actual=response required=none", d);
        end else begin
            e = d ? q1.pop_front() : q0.pop_front();
            check32($sformatf("dut%0d_pslverr", d), {31'b0, err}, {31'b0, e.err});
            check32($sformatf("dut%0d_prdata", d), rd, e.rdata);
            check32($sformatf("dut%0d_latency", d), 32'(lat), 32'(e.lat));
        end
    endtask

    always @(negedge pclk) begin
        if (!preset_n || !(bus0.psel && bus0.penable)) begin
            acc0 = 0;
        end else if (!bus0.pready) begin
            acc0++;
        end else begin
            mon_cmp(1'b0, bus0.pslverr, bus0.prdata, acc0 + 1);
            acc0 = 0;
        end
    end

    always @(negedge pclk) begin
        if (!preset_n || !(bus1.psel && bus1.penable)) begin
            acc1 = 0;
        end else if (!bus1.pready) begin
            acc1++;
        end else begin
            mon_cmp(1'b1, bus1.pslverr, bus1.prdata, acc1 + 1);
            acc1 = 0;
        end
    end

    task automatic xfer(input bit d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] s, input logic [2:0] pr,
                        input logic e_err, input logic [31:0] e_rd);
        exp_t e;
        bit   seen;
        e.err   = e_err;
        e.rdata = e_rd;
        e.lat   = d ? 4 : 1;
        if (d) q1.push_back(e); else q0.push_back(e);
        @(posedge pclk) #1;
        dsel = d; psel = 1'b1; penable = 1'b0; pwrite = w;
        paddr = a; pwdata = wd; pstrb = s; pprot = pr;
        @(posedge pclk) #1;
        penable = 1'b1;
        // Access-phase bus changes must not affect the transfer.
        paddr = ~a; pwdata = ~wd; pstrb = ~s;
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge pclk);
            seen = d ? bus1.pready : bus0.pready;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL timeout_dut%0d actual=no_pready required=pready", d);
        end
        @(posedge pclk) #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    initial begin
        logic [7:0] wp_acc;
        dsel = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        pprot = 3'b000; paddr = '0; pwdata = '0; pstrb = '0;
        for (int i = 0; i < 8; i++) begin m0[i] = 32'h0; m1[i] = 32'h0; end
        m0[0] = ID; m1[0] = ID;

        repeat (3) @(posedge pclk);
        #1 preset_n = 1'b1;
        #1;
        check32("rst_resp0", {bus0.pready, bus0.pslverr, 30'b0} | bus0.prdata, 32'h0);
        check32("rst_resp1", {bus1.pready, bus1.pslverr, 30'b0} | bus1.prdata, 32'h0);
        check_regs("rst_regs0", regq0, pack(m0));
        check32("rst_wp", {16'h0, wp0, wp1}, 32'h0);

        xfer(1'b0, 1'b1, 32'h04, 32'h1234_5678, 4'hF, 3'b000, 1'b0, 32'h0);
        check32("wr1_pulse", {24'h0, wp0}, 32'h02);
        check32("wr1_reg1", regq0[63:32], 32'h1234_5678);
        @(posedge pclk) #1;
        check32("wr1_pulse_gone", {24'h0, wp0}, 32'h00);
        m0[1] = 32'h1234_5678;

        xfer(1'b1, 1'b0, 32'h00, 32'h0, 4'h0, 3'b000, 1'b0, ID);

        xfer(1'b0, 1'b1, 32'h04, 32'hAABB_CCDD, 4'b0101, 3'b000, 1'b0, 32'h0);
        m0[1] = 32'h12BB_56DD;
        check_regs("strb_regs0", regq0, pack(m0));
        xfer(1'b0, 1'b0, 32'h04, 32'h0, 4'h0, 3'b000, 1'b0, 32'h12BB_56DD);

        xfer(1'b0, 1'b1, 32'h00, 32'hFFFF_FFFF, 4'hF, 3'b000, 1'b1, 32'h0);
        check32("errwr_pulse", {24'h0, wp0}, 32'h00);
        xfer(1'b0, 1'b0, 32'h20, 32'h0, 4'h0, 3'b000, 1'b1, 32'h0);
        xfer(1'b0, 1'b0, 32'h06, 32'h0, 4'h0, 3'b000, 1'b1, 32'h0);
        check_regs("err_regs0", regq0, pack(m0));

        xfer(1'b0, 1'b1, 32'h08, 32'hFFFF_FFFF, 4'h0, 3'b000, 1'b0, 32'h0);
        check32("strb0_pulse", {24'h0, wp0}, 32'h04);
        check_regs("strb0_regs0", regq0, pack(m0));

        xfer(1'b0, 1'b1, 32'h1C, 32'hCAFE_F00D, 4'hF, 3'b000, 1'b0, 32'h0);
        m0[7] = 32'hCAFE_F00D;
        xfer(1'b0, 1'b0, 32'h1C, 32'h0, 4'h0, 3'b000, 1'b0, 32'hCAFE_F00D);
        xfer(1'b0, 1'b0, 32'h00, 32'h0, 4'h0, 3'b000, 1'b0, ID);

        xfer(1'b1, 1'b1, 32'h00, 32'h1111_1111, 4'hF, 3'b000, 1'b1, 32'h0);
        xfer(1'b1, 1'b1, 32'h08, 32'h55AA_55AA, 4'hF, 3'b000, 1'b0, 32'h0);
        check32("w3_pulse", {24'h0, wp1}, 32'h04);
        m1[2] = 32'h55AA_55AA;
        check_regs("w3_regs1", regq1, pack(m1));

        // Abort: psel dropped after one wait cycle.
        @(posedge pclk) #1;
        dsel = 1'b1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'h0C; pwdata = 32'h7777_7777; pstrb = 4'hF;
        @(posedge pclk) #1 penable = 1'b1;
        @(posedge pclk) #1 begin psel = 1'b0; penable = 1'b0; end
        wp_acc = '0;
        repeat (6) begin @(posedge pclk) #1; wp_acc = wp_acc | wp1; end
        check32("abort_pulse", {24'h0, wp_acc}, 32'h0);
        check_regs("abort_regs1", regq1, pack(m1));
        xfer(1'b1, 1'b0, 32'h0C, 32'h0, 4'h0, 3'b000, 1'b0, 32'h0);

        // Reset in the second wait cycle of a write.
        @(posedge pclk) #1;
        dsel = 1'b1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'h08; pwdata = 32'h0BAD_F00D; pstrb = 4'hF;
        @(posedge pclk) #1 penable = 1'b1;
        @(posedge pclk) #1 preset_n = 1'b0;
        #1;
        check32("rstmid_pready", {31'b0, bus1.pready}, 32'h0);
        check32("rstmid_reg2", regq1[95:64], 32'h0);
        psel = 1'b0; penable = 1'b0;
        @(posedge pclk) #1 preset_n = 1'b1;
        wp_acc = '0;
        repeat (6) begin @(posedge pclk) #1; wp_acc = wp_acc | wp1 | wp0; end
        check32("rstmid_pulse", {24'h0, wp_acc}, 32'h0);
        for (int i = 1; i < 8; i++) begin m0[i] = 32'h0; m1[i] = 32'h0; end
        check_regs("rstmid_regs1", regq1, pack(m1));
        check_regs("rstmid_regs0", regq0, pack(m0));

`ifdef APB_REGFILE_PROT_EN
        xfer(1'b0, 1'b1, 32'h10, 32'h1111_2222, 4'hF, 3'b000, 1'b1, 32'h0);
        check_regs("prot_block_regs0", regq0, pack(m0));
        xfer(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 3'b000, 1'b1, 32'h0);
`else
        xfer(1'b0, 1'b1, 32'h10, 32'h1111_2222, 4'hF, 3'b000, 1'b0, 32'h0);
        m0[4] = 32'h1111_2222;
        check_regs("noprot_regs0", regq0, pack(m0));
`endif
        xfer(1'b0, 1'b1, 32'h10, 32'h3333_4444, 4'hF, 3'b001, 1'b0, 32'h0);
        m0[4] = 32'h3333_4444;
        check_regs("prot_ok_regs0", regq0, pack(m0));

        repeat (3) @(posedge pclk);
        check32("sb_drained", 32'(q0.size() + q1.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
